// File: rtl/regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2w2r_sb
// Description : Parametrised register file with two combinational read
//               ports, two synchronous write ports (B has priority), an
//               optional same-cycle write-to-read bypass and a per-register
//               busy scoreboard for tracking pending producers.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2w2r_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_busy1,
    output logic              read_busy2,
    input  logic              RegWrite_a,
    input  logic [ADDR_W-1:0] write_reg_a,
    input  logic [DATA_W-1:0] write_data_a,
    input  logic              RegWrite_b,
    input  logic [ADDR_W-1:0] write_reg_b,
    input  logic [DATA_W-1:0] write_data_b,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_reg
);

    localparam bit c_ZERO   = (ZERO_REG != 0);
    localparam bit c_BYPASS = (BYPASS != 0);

    // Architectural state
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    // Qualified enables: anything aimed at a hardwired zero register is dropped
    logic w_we_a;
    logic w_we_b;
    logic w_alloc;

    // One-hot per-register strobes derived from the qualified enables
    logic [NUM_REGS-1:0] w_wsel_a;
    logic [NUM_REGS-1:0] w_wsel_b;
    logic [NUM_REGS-1:0] w_asel;

    // Bypass is only live outside reset so reads during reset show storage
    logic w_byp_en;

    // Qualify write/alloc enables against the zero register
    always_comb begin
        w_we_a   = RegWrite_a && !(c_ZERO && (write_reg_a == '0));
        w_we_b   = RegWrite_b && !(c_ZERO && (write_reg_b == '0));
        w_alloc  = alloc_en   && !(c_ZERO && (alloc_reg   == '0));
        w_byp_en = c_BYPASS && !rst;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign w_wsel_a[gi] = w_we_a  && (write_reg_a == ADDR_W'(gi));
            assign w_wsel_b[gi] = w_we_b  && (write_reg_b == ADDR_W'(gi));
            assign w_asel[gi]   = w_alloc && (alloc_reg   == ADDR_W'(gi));
        end
    endgenerate

    // Register array update; port B overrides port A on an index collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wsel_b[i]) begin
                    r_regs[i] <= write_data_b;
                end else if (w_wsel_a[i]) begin
                    r_regs[i] <= write_data_a;
                end
            end
        end
    end

    // Scoreboard update; a new allocation wins over a completing write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~(w_wsel_a | w_wsel_b)) | w_asel;
        end
    end

    // Shared read lookup: returns {busy, data} for one read index
    function automatic logic [DATA_W:0] read_lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v_data;
        logic              v_busy;
        logic              v_hit_a;
        logic              v_hit_b;
        v_hit_a = w_byp_en && w_we_a && (write_reg_a == addr);
        v_hit_b = w_byp_en && w_we_b && (write_reg_b == addr);
        v_data  = r_regs[addr];
        v_busy  = r_busy[addr];
        if (v_hit_b) begin
            v_data = write_data_b;
        end else if (v_hit_a) begin
            v_data = write_data_a;
        end
        // A completing write makes the value available now, so hide busy
        if (v_hit_a || v_hit_b) begin
            v_busy = 1'b0;
        end
        if (c_ZERO && (addr == '0)) begin
            v_data = '0;
            v_busy = 1'b0;
        end
        return {v_busy, v_data};
    endfunction

    // Read port 1
    always_comb begin
        {read_busy1, read_data1} = read_lookup(read_reg1);
    end

    // Read port 2
    always_comb begin
        {read_busy2, read_data2} = read_lookup(read_reg2);
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_2w2r_sb
// Description : Self-checking bench for regfile_2w2r_sb. A default-parameter
//               instance (bypass on) and a narrow instance (16-bit, 8 regs,
//               bypass off) are driven by a vector table, hand sequences and
//               random traffic compared against array-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2w2r_sb;

    logic clk;
    logic rst;

    // Main instance: DATA_W=32, NUM_REGS=32, bypass on
    logic [4:0]  rr1, rr2, wa, wb, ar;
    logic [31:0] rd1, rd2, wda, wdb;
    logic        rb1, rb2, wea, web, alen;

    // Narrow instance: DATA_W=16, NUM_REGS=8, bypass off
    logic [2:0]  n_rr1, n_rr2, n_wa, n_wb, n_ar;
    logic [15:0] n_rd1, n_rd2, n_wda, n_wdb;
    logic        n_rb1, n_rb2, n_wea, n_web, n_alen;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [15:0] nm_regs [8];
    logic        nm_busy [8];

    regfile_2w2r_sb u_dut (
        .clk(clk), .rst(rst),
        .read_reg1(rr1), .read_reg2(rr2),
        .read_data1(rd1), .read_data2(rd2),
        .read_busy1(rb1), .read_busy2(rb2),
        .RegWrite_a(wea), .write_reg_a(wa), .write_data_a(wda),
        .RegWrite_b(web), .write_reg_b(wb), .write_data_b(wdb),
        .alloc_en(alen), .alloc_reg(ar)
    );

    regfile_2w2r_sb #(
        .DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)
    ) u_dut_nb (
        .clk(clk), .rst(rst),
        .read_reg1(n_rr1), .read_reg2(n_rr2),
        .read_data1(n_rd1), .read_data2(n_rd2),
        .read_busy1(n_rb1), .read_busy2(n_rb2),
        .RegWrite_a(n_wea), .write_reg_a(n_wa), .write_data_a(n_wda),
        .RegWrite_b(n_web), .write_reg_b(n_wb), .write_data_b(n_wdb),
        .alloc_en(n_alen), .alloc_reg(n_ar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wea; logic [4:0] wa; logic [31:0] wda;
        logic        web; logic [4:0] wb; logic [31:0] wdb;
        logic        al;  logic [4:0] ar;
        logic [4:0]  r1;  logic [4:0] r2;
        logic [31:0] d1;  logic b1;
        logic [31:0] d2;  logic b2;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mkv(
        logic r, logic ea, logic [4:0] a, logic [31:0] da,
        logic eb, logic [4:0] b, logic [31:0] db,
        logic al, logic [4:0] alr, logic [4:0] q1, logic [4:0] q2,
        logic [31:0] d1, logic b1, logic [31:0] d2, logic b2);
        vec_t v;
        v.rst = r; v.wea = ea; v.wa = a; v.wda = da;
        v.web = eb; v.wb = b; v.wdb = db; v.al = al; v.ar = alr;
        v.r1 = q1; v.r2 = q2; v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected {busy,data} on the main instance from the architectural rules
    function automatic logic [32:0] exp_main(input logic [4:0] a);
        logic [31:0] d;
        logic        b;
        logic        wr;
        if (a == 0) return 33'h0;
        d  = m_regs[a];
        b  = m_busy[a];
        wr = 1'b0;
        if (!rst && wea && wa == a) begin d = wda; wr = 1'b1; end
        if (!rst && web && wb == a) begin d = wdb; wr = 1'b1; end
        if (wr) b = 1'b0;
        return {b, d};
    endfunction

    // Expected {busy,data} on the narrow instance: plain storage read
    function automatic logic [16:0] exp_nb(input logic [2:0] a);
        if (a == 0) return 17'h0;
        return {nm_busy[a], nm_regs[a]};
    endfunction

    task automatic check_models(input string tag);
        logic [32:0] e1, e2;
        logic [16:0] f1, f2;
        e1 = exp_main(rr1);
        e2 = exp_main(rr2);
        f1 = exp_nb(n_rr1);
        f2 = exp_nb(n_rr2);
        chk({tag, " m_d1"}, rd1, e1[31:0]);
        chk({tag, " m_b1"}, {31'b0, rb1}, {31'b0, e1[32]});
        chk({tag, " m_d2"}, rd2, e2[31:0]);
        chk({tag, " m_b2"}, {31'b0, rb2}, {31'b0, e2[32]});
        chk({tag, " n_d1"}, {16'b0, n_rd1}, {16'b0, f1[15:0]});
        chk({tag, " n_b1"}, {31'b0, n_rb1}, {31'b0, f1[16]});
        chk({tag, " n_d2"}, {16'b0, n_rd2}, {16'b0, f2[15:0]});
        chk({tag, " n_b2"}, {31'b0, n_rb2}, {31'b0, f2[16]});
    endtask

    // Advance reference state for the edge that is about to happen
    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
            for (int i = 0; i < 8; i++)  begin nm_regs[i] = '0; nm_busy[i] = 1'b0; end
        end else begin
            if (wea && wa != 0) begin m_regs[wa] = wda; m_busy[wa] = 1'b0; end
            if (web && wb != 0) begin m_regs[wb] = wdb; m_busy[wb] = 1'b0; end
            if (alen && ar != 0) m_busy[ar] = 1'b1;
            if (n_wea && n_wa != 0) begin nm_regs[n_wa] = n_wda; nm_busy[n_wa] = 1'b0; end
            if (n_web && n_wb != 0) begin nm_regs[n_wb] = n_wdb; nm_busy[n_wb] = 1'b0; end
            if (n_alen && n_ar != 0) nm_busy[n_ar] = 1'b1;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic main_idle();
        wea = 0; wa = 0; wda = 0; web = 0; wb = 0; wdb = 0; alen = 0; ar = 0;
        rr1 = 0; rr2 = 0;
    endtask

    task automatic nb_drive(input logic ea, input logic [2:0] a, input logic [15:0] da,
                            input logic eb, input logic [2:0] b, input logic [15:0] db,
                            input logic al, input logic [2:0] alr,
                            input logic [2:0] q1, input logic [2:0] q2);
        n_wea = ea; n_wa = a; n_wda = da; n_web = eb; n_wb = b; n_wdb = db;
        n_alen = al; n_ar = alr; n_rr1 = q1; n_rr2 = q2;
    endtask

    task automatic nb_step(input string tag, input logic [15:0] d1, input logic b1,
                           input logic [15:0] d2, input logic b2);
        @(negedge clk);
        chk({tag, " d1"}, {16'b0, n_rd1}, {16'b0, d1});
        chk({tag, " b1"}, {31'b0, n_rb1}, {31'b0, b1});
        chk({tag, " d2"}, {16'b0, n_rd2}, {16'b0, d2});
        chk({tag, " b2"}, {31'b0, n_rb2}, {31'b0, b2});
        tick();
    endtask

    function automatic logic [4:0] rnd_a5();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        for (int i = 0; i < 8; i++)  begin nm_regs[i] = '0; nm_busy[i] = 1'b0; end
        rst = 1'b1;
        main_idle();
        nb_drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        //           rst ea wa  wda           eb wb  wdb          al ar  r1  r2   d1            b1 d2            b2
        tbl[0]  = mkv(1, 1, 5,  32'h1234,     0, 0,  0,           0, 0,  1,  5,   0,            0, 0,            0);
        tbl[1]  = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  5,  2,   0,            0, 0,            0);
        tbl[2]  = mkv(0, 1, 7,  32'hAAAA,     1, 7,  32'hBBBB,    0, 0,  7,  0,   32'hBBBB,     0, 0,            0);
        tbl[3]  = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  7,  7,   32'hBBBB,     0, 32'hBBBB,     0);
        tbl[4]  = mkv(0, 1, 0,  32'hFFFFFFFF, 0, 0,  0,           1, 0,  0,  0,   0,            0, 0,            0);
        tbl[5]  = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  0,  7,   0,            0, 32'hBBBB,     0);
        tbl[6]  = mkv(0, 0, 0,  0,            0, 0,  0,           1, 3,  3,  3,   0,            0, 0,            0);
        tbl[7]  = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  3,  7,   0,            1, 32'hBBBB,     0);
        tbl[8]  = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  3,  3,   0,            1, 0,            1);
        tbl[9]  = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  3,  3,   0,            1, 0,            1);
        tbl[10] = mkv(0, 0, 0,  0,            1, 3,  32'h55,      0, 0,  3,  3,   32'h55,       0, 32'h55,       0);
        tbl[11] = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  3,  7,   32'h55,       0, 32'hBBBB,     0);
        tbl[12] = mkv(0, 0, 0,  0,            0, 0,  0,           1, 9,  9,  9,   0,            0, 0,            0);
        tbl[13] = mkv(0, 1, 9,  32'h10,       0, 0,  0,           1, 9,  9,  3,   32'h10,       0, 32'h55,       0);
        tbl[14] = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  9,  9,   32'h10,       1, 32'h10,       1);
        tbl[15] = mkv(0, 1, 9,  32'h33,       1, 9,  32'h22,      1, 12, 9,  12,  32'h22,       0, 0,            0);
        tbl[16] = mkv(0, 0, 0,  0,            0, 0,  0,           0, 0,  9,  12,  32'h22,       0, 0,            1);

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst;
            wea = tbl[i].wea; wa = tbl[i].wa; wda = tbl[i].wda;
            web = tbl[i].web; wb = tbl[i].wb; wdb = tbl[i].wdb;
            alen = tbl[i].al; ar = tbl[i].ar;
            rr1 = tbl[i].r1; rr2 = tbl[i].r2;
            @(negedge clk);
            chk($sformatf("vec%0d d1", i), rd1, tbl[i].d1);
            chk($sformatf("vec%0d b1", i), {31'b0, rb1}, {31'b0, tbl[i].b1});
            chk($sformatf("vec%0d d2", i), rd2, tbl[i].d2);
            chk($sformatf("vec%0d b2", i), {31'b0, rb2}, {31'b0, tbl[i].b2});
            tick();
        end

        // Narrow instance without bypass: writes and busy-clears appear one cycle later
        rst = 1'b0;
        main_idle();
        nb_drive(1, 4, 16'h0099, 0, 0, 0, 0, 0, 4, 4); nb_step("nb_wr_same", 16'h0, 0, 16'h0, 0);
        nb_drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);        nb_step("nb_wr_next", 16'h99, 0, 16'h0, 0);
        nb_drive(1, 7, 16'hAAAA, 1, 7, 16'hBBBB, 0, 0, 7, 4); nb_step("nb_dual_same", 16'h0, 0, 16'h99, 0);
        nb_drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);        nb_step("nb_dual_next", 16'hBBBB, 0, 16'hBBBB, 0);
        nb_drive(0, 0, 0, 0, 0, 0, 1, 2, 2, 2);        nb_step("nb_alloc", 16'h0, 0, 16'h0, 0);
        nb_drive(0, 0, 0, 1, 2, 16'h0055, 0, 0, 2, 2); nb_step("nb_clr_same", 16'h0, 1, 16'h0, 1);
        nb_drive(0, 0, 0, 0, 0, 0, 0, 0, 2, 7);        nb_step("nb_clr_next", 16'h55, 0, 16'hBBBB, 0);
        nb_drive(1, 0, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0); nb_step("nb_zero_same", 16'h0, 0, 16'h0, 0);
        nb_drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);        nb_step("nb_zero_next", 16'h0, 0, 16'hBBBB, 0);

        // Random traffic on both instances against the reference models
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 49) == 0);
            wea  = 1'($urandom_range(0, 1)); wa = rnd_a5(); wda = $urandom;
            web  = 1'($urandom_range(0, 1)); wb = rnd_a5(); wdb = $urandom;
            alen = 1'($urandom_range(0, 1)); ar = rnd_a5();
            rr1  = rnd_a5(); rr2 = rnd_a5();
            nb_drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            @(negedge clk);
            check_models($sformatf("rnd%0d", c));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
